vec_sequencer: RTL and testbench
================================

Name: vec_sequencer

Overview:
- Parametrised successor to the vector top-level controller.
- Accepts vector commands through a small command FIFO and strip-mines each command over `lanes_p` lanes, using a per-command runtime vector length.
- Issues per-strip start pulses with lane masks to the lanes, and tracks lane completion.
- Assembles read results and returns them over a valid/yumi interface.
- Sits between the host command port and the lane/VRF array.

Parameters:
- `lanes_p`, 4: number of lanes; must divide nothing, since partial strips are allowed.
- `vlen_p`, 16: maximum elements per vector.
- `els_p`, 8: vectors in the VRF; sets address width `clog2(els_p)`.
- `vdw_p`, 8: bits per element.
- `op_width_p`, 4: opcode width.
- `cmd_fifo_els_p`, 2: command FIFO depth; must be ≥1.

Ports:
- `clk_i`  in  1  clock
- `reset_n_i`  in  1  asynchronous active-low reset
- `cmd_v_i`  in  1  command valid
- `cmd_ready_o`  out  1  FIFO not full
- `cmd_op_i`  in  `op_width_p`  opcode (0000 add, 0001 sub, 0010 mul, 0100–0110 vector-scalar forms, 1000 read, 1001 write)
- `cmd_addr_a_i` / `cmd_addr_b_i` / `cmd_addr_d_i`  in  `clog2(els_p)`  operand and destination vectors
- `cmd_vl_i`  in  `clog2(vlen_p+1)`  vector length
- `cmd_scalar_i`  in  `vdw_p`  scalar operand
- `cmd_wdata_i`  in  `vlen_p*vdw_p`  write data; element k is at `[k*vdw_p +: vdw_p]`
- `lane_start_o`  out  `lanes_p`  one-cycle start per active lane
- `lane_op_o`  out  `op_width_p`
- `lane_addr_a_o` / `lane_addr_b_o` / `lane_addr_d_o`  out  `clog2(els_p)`
- `lane_scalar_o`  out  `vdw_p`
- `lane_strip_o`  out  `clog2(vlen_p)`  current strip index
- `lane_wdata_o`  out  `lanes_p*vdw_p`  current strip write slice
- `lane_done_i`  in  `lanes_p`  per-lane done pulse
- `lane_v_i`  in  `lanes_p`  per-lane read-data valid
- `lane_data_i`  in  `lanes_p*vdw_p`  read data
- `resp_v_o`  out  1  read result valid
- `resp_data_o`  out  `vlen_p*vdw_p`  read result
- `resp_yumi_i`  in  1  result consumed
- `done_o`  out  1  one-cycle pulse per retired command
- `busy_o`  out  1  FSM not IDLE or FIFO not empty

Behaviour:
- **Reset** (async, `reset_n_i`=0):
  - FSM goes to IDLE and the FIFO is emptied.
  - Outputs: `cmd_ready_o`=1; `lane_start_o`, `resp_v_o`, `done_o`, `busy_o` = 0; `resp_data_o`=0; all other registered outputs 0.
  - Reset mid-command abandons the command; no `done_o` is produced.
- **Command FIFO:**
  - Enqueue when `cmd_v_i & cmd_ready_o`.
  - Entry is visible at the head the cycle after write.
  - Simultaneous push and pop on a full FIFO is not allowed: `cmd_ready_o` is computed from the registered full flag only.
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
  - IDLE: FIFO non-empty → pop the head into a working register and go to ISSUE. Strip counter = 0; `vl_eff` = min(`cmd_vl_i`, `vlen_p`).
  - IDLE with `vl_eff`=0: go straight back to IDLE, pulse `done_o` the next cycle, issue no lane start. A read with `vl_eff`=0 goes to RESP with all-zero data.
  - ISSUE (exactly 1 cycle): `lane_start_o` = mask.
    - mask[i] = (strip*`lanes_p` + i < `vl_eff`).
    - `lane_strip_o` = strip.
    - `lane_wdata_o` = elements strip*`lanes_p` .. +`lanes_p`-1 of the latched wdata, with masked-off slots forced to 0.
    - Next state: WAIT.
  - WAIT:
    - Per-lane sticky done bits set on `lane_done_i` (done from unmasked lanes is ignored).
    - On `lane_v_i[i]` with mask[i]: element strip*`lanes_p`+i of the result buffer ← `lane_data_i` slice.
    - When all masked lanes are done (including done arriving in the same cycle), clear the sticky bits.
    - Not last strip → strip+1, go to ISSUE.
    - Last strip (strip = ceil(`vl_eff`/`lanes_p`)-1) with a read op → RESP; otherwise → IDLE with `done_o` pulsed in the cycle IDLE is entered.
  - RESP: `resp_v_o`=1 and `resp_data_o` held stable until `resp_yumi_i`. On yumi: `done_o` pulses, go to IDLE.
- **Result buffer:** cleared on each pop. Elements ≥ `vl_eff` read as 0.
- **Latency:** command accepted at edge N → `lane_start_o` asserted in cycle N+2.
- **Back-to-back commands:** in IDLE the next command pops in the same cycle `done_o` pulses.
- **Stable outputs:** `lane_op_o`, addresses and scalar are held stable from ISSUE through the end of the command.

Optional Feature:
- Macro: `VEC_SEQ_PERF_CNT_EN`.
- When defined, adds output `perf_busy_cycles_o` (32b), incremented every cycle `busy_o`=1.
- Also adds output `perf_cmds_o` (16b), incremented on each `done_o`.
- Both counters saturate and are cleared by reset.
- When undefined, these ports and counters do not exist.

Test Plan:
- Add with `vl`=16, `lanes_p`=4, lanes returning done 3 cycles after start → four ISSUE pulses with mask 1111 and strips 0..3; one `done_o`; no `resp_v_o`.
- Read with `vl`=6, lanes return data = element index → masks 1111 then 0011; `resp_data_o` elements 0..5 = 0..5, elements 6..15 = 0; `resp_v_o` held until yumi; then `done_o`.
- Command with `vl`=0, and a separate command with `vl`=20 (clamped to 16) → first gives `done_o` with no `lane_start_o`; second gives 4 strips.
- Three commands pushed back-to-back with `cmd_fifo_els_p`=2 → `cmd_ready_o` drops while full; all three retire in order with three `done_o` pulses.
- Assert `reset_n_i` in WAIT of strip 1 → outputs go to their reset values immediately (async); no `done_o`; a new command afterwards executes normally.

Source files
------------

// File: rtl/vec_sequencer.sv
// Vector command sequencer: queues commands, strip-mines them over lanes_p lanes and returns read results.
// Define VEC_SEQ_PERF_CNT_EN to add saturating busy-cycle and retired-command counters.
module vec_sequencer #(
    parameter int lanes_p        = 4,
    parameter int vlen_p         = 16,
    parameter int els_p          = 8,
    parameter int vdw_p          = 8,
    parameter int op_width_p     = 4,
    parameter int cmd_fifo_els_p = 2,
    localparam int AW  = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int VLW = $clog2(vlen_p + 1),
    localparam int SW  = (vlen_p > 1) ? $clog2(vlen_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      cmd_v_i,
    output logic                      cmd_ready_o,
    input  logic [op_width_p-1:0]     cmd_op_i,
    input  logic [AW-1:0]             cmd_addr_a_i,
    input  logic [AW-1:0]             cmd_addr_b_i,
    input  logic [AW-1:0]             cmd_addr_d_i,
    input  logic [VLW-1:0]            cmd_vl_i,
    input  logic [vdw_p-1:0]          cmd_scalar_i,
    input  logic [vlen_p*vdw_p-1:0]   cmd_wdata_i,
    output logic [lanes_p-1:0]        lane_start_o,
    output logic [op_width_p-1:0]     lane_op_o,
    output logic [AW-1:0]             lane_addr_a_o,
    output logic [AW-1:0]             lane_addr_b_o,
    output logic [AW-1:0]             lane_addr_d_o,
    output logic [vdw_p-1:0]          lane_scalar_o,
    output logic [SW-1:0]             lane_strip_o,
    output logic [lanes_p*vdw_p-1:0]  lane_wdata_o,
    input  logic [lanes_p-1:0]        lane_done_i,
    input  logic [lanes_p-1:0]        lane_v_i,
    input  logic [lanes_p*vdw_p-1:0]  lane_data_i,
    output logic                      resp_v_o,
    output logic [vlen_p*vdw_p-1:0]   resp_data_o,
    input  logic                      resp_yumi_i,
    output logic                      done_o,
    output logic                      busy_o
`ifdef VEC_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]               perf_busy_cycles_o,
    output logic [15:0]               perf_cmds_o
`endif
);

    localparam int PW = (cmd_fifo_els_p > 1) ? $clog2(cmd_fifo_els_p) : 1;
    localparam int CW = $clog2(cmd_fifo_els_p + 1);
    localparam logic [31:0] LANES32 = 32'(lanes_p);
    localparam logic [op_width_p-1:0] OP_READ = op_width_p'(8);

    typedef struct packed {
        logic [op_width_p-1:0]   op;
        logic [AW-1:0]           a;
        logic [AW-1:0]           b;
        logic [AW-1:0]           d;
        logic [VLW-1:0]          vl;
        logic [vdw_p-1:0]        scalar;
        logic [vlen_p*vdw_p-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Command FIFO
    cmd_t           fifo_mem_q [cmd_fifo_els_p];
    cmd_t           cmd_in;
    cmd_t           head;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           full_q, full_d;
    logic           push, pop;

    // Working command and sequencing state
    state_t                  state_q, state_d;
    cmd_t                    cmd_q, cmd_d;
    logic [SW-1:0]           strip_q, strip_d;
    logic [lanes_p-1:0]      sticky_q, sticky_d;
    logic [vlen_p*vdw_p-1:0] result_q, result_d;
    logic                    done_q, done_d;
    logic [lanes_p-1:0]      mask;
    logic                    all_done;
    logic                    last_strip;
    logic [VLW-1:0]          head_vl_eff;

    assign cmd_ready_o = ~full_q;
    assign push        = cmd_v_i & ~full_q;
    assign head        = fifo_mem_q[rd_ptr_q];

    always_comb begin
        cmd_in.op     = cmd_op_i;
        cmd_in.a      = cmd_addr_a_i;
        cmd_in.b      = cmd_addr_b_i;
        cmd_in.d      = cmd_addr_d_i;
        cmd_in.vl     = cmd_vl_i;
        cmd_in.scalar = cmd_scalar_i;
        cmd_in.wdata  = cmd_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= cmd_in;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(cmd_fifo_els_p - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(cmd_fifo_els_p - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        full_d = (count_d == CW'(cmd_fifo_els_p));
    end

    // Lane i is active in this strip when its element index lies below the vector length
    for (genvar gi = 0; gi < lanes_p; gi++) begin : g_mask
        assign mask[gi] = (32'(strip_q) * LANES32 + 32'(gi)) < 32'(cmd_q.vl);
    end

    assign all_done    = &(sticky_q | (lane_done_i & mask) | ~mask);
    assign last_strip  = ((32'(strip_q) + 32'd1) * LANES32) >= 32'(cmd_q.vl);
    assign head_vl_eff = (head.vl > VLW'(vlen_p)) ? VLW'(vlen_p) : head.vl;

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        strip_d  = strip_q;
        sticky_d = sticky_q;
        result_d = result_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop      = 1'b1;
                    cmd_d    = head;
                    cmd_d.vl = head_vl_eff;
                    strip_d  = '0;
                    sticky_d = '0;
                    result_d = '0;
                    if (head_vl_eff != '0) begin
                        state_d = ISSUE;
                    end else if (head.op == OP_READ) begin
                        state_d = RESP;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                for (int k = 0; k < vlen_p; k++) begin
                    if (strip_q == SW'(k / lanes_p) && mask[k % lanes_p] && lane_v_i[k % lanes_p]) begin
                        result_d[k*vdw_p +: vdw_p] = lane_data_i[(k % lanes_p)*vdw_p +: vdw_p];
                    end
                end
                if (all_done) begin
                    sticky_d = '0;
                    if (!last_strip) begin
                        strip_d = strip_q + SW'(1);
                        state_d = ISSUE;
                    end else if (cmd_q.op == OP_READ) begin
                        state_d = RESP;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    sticky_d = sticky_q | (lane_done_i & mask);
                end
            end
            RESP: begin
                if (resp_yumi_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            state_q  <= IDLE;
            cmd_q    <= '0;
            strip_q  <= '0;
            sticky_q <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            strip_q  <= strip_d;
            sticky_q <= sticky_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Write slice for the current strip; slots of inactive lanes are zeroed
    always_comb begin
        lane_wdata_o = '0;
        for (int k = 0; k < vlen_p; k++) begin
            if (strip_q == SW'(k / lanes_p) && mask[k % lanes_p]) begin
                lane_wdata_o[(k % lanes_p)*vdw_p +: vdw_p] = cmd_q.wdata[k*vdw_p +: vdw_p];
            end
        end
    end

    assign lane_start_o  = (state_q == ISSUE) ? mask : '0;
    assign lane_op_o     = cmd_q.op;
    assign lane_addr_a_o = cmd_q.a;
    assign lane_addr_b_o = cmd_q.b;
    assign lane_addr_d_o = cmd_q.d;
    assign lane_scalar_o = cmd_q.scalar;
    assign lane_strip_o  = strip_q;
    assign resp_v_o      = (state_q == RESP);
    assign resp_data_o   = result_q;
    assign done_o        = done_q;
    assign busy_o        = (state_q != IDLE) || (count_q != '0);

`ifdef VEC_SEQ_PERF_CNT_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [15:0] perf_cmds_q, perf_cmds_d;

    always_comb begin
        perf_busy_d = perf_busy_q;
        perf_cmds_d = perf_cmds_q;
        if (busy_o && perf_busy_q != '1) begin
            perf_busy_d = perf_busy_q + 32'd1;
        end
        if (done_q && perf_cmds_q != '1) begin
            perf_cmds_d = perf_cmds_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_busy_q <= '0;
            perf_cmds_q <= '0;
        end else begin
            perf_busy_q <= perf_busy_d;
            perf_cmds_q <= perf_cmds_d;
        end
    end

    assign perf_busy_cycles_o = perf_busy_q;
    assign perf_cmds_o        = perf_cmds_q;
`endif

endmodule

// File: tb/tb_vec_sequencer.sv
// Self-checking bench for vec_sequencer: reactive lane model plus issue/done/response scoreboards.
module tb_vec_sequencer;

    localparam int LANES = 4;
    localparam int VLEN  = 16;
    localparam int VDW   = 8;
    localparam int AW    = 3;
    localparam int VLW   = 5;
    localparam int SW    = 4;
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_READ  = 4'b1000;
    localparam logic [3:0] OP_WRITE = 4'b1001;

    logic                     clk_i = 1'b0;
    logic                     reset_n_i = 1'b0;
    logic                     cmd_v_i = 1'b0;
    logic                     cmd_ready_o;
    logic [3:0]               cmd_op_i = '0;
    logic [AW-1:0]            cmd_addr_a_i = '0;
    logic [AW-1:0]            cmd_addr_b_i = '0;
    logic [AW-1:0]            cmd_addr_d_i = '0;
    logic [VLW-1:0]           cmd_vl_i = '0;
    logic [VDW-1:0]           cmd_scalar_i = '0;
    logic [VLEN*VDW-1:0]      cmd_wdata_i = '0;
    logic [LANES-1:0]         lane_start_o;
    logic [3:0]               lane_op_o;
    logic [AW-1:0]            lane_addr_a_o, lane_addr_b_o, lane_addr_d_o;
    logic [VDW-1:0]           lane_scalar_o;
    logic [SW-1:0]            lane_strip_o;
    logic [LANES*VDW-1:0]     lane_wdata_o;
    logic [LANES-1:0]         lane_done_i = '0;
    logic [LANES-1:0]         lane_v_i = '0;
    logic [LANES*VDW-1:0]     lane_data_i = '0;
    logic                     resp_v_o;
    logic [VLEN*VDW-1:0]      resp_data_o;
    logic                     resp_yumi_i = 1'b0;
    logic                     done_o;
    logic                     busy_o;
`ifdef VEC_SEQ_PERF_CNT_EN
    logic [31:0]              perf_busy_cycles_o;
    logic [15:0]              perf_cmds_o;
`endif

    always #5 clk_i = ~clk_i;

    vec_sequencer dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
        .cmd_addr_a_i(cmd_addr_a_i), .cmd_addr_b_i(cmd_addr_b_i), .cmd_addr_d_i(cmd_addr_d_i),
        .cmd_vl_i(cmd_vl_i), .cmd_scalar_i(cmd_scalar_i), .cmd_wdata_i(cmd_wdata_i),
        .lane_start_o(lane_start_o), .lane_op_o(lane_op_o),
        .lane_addr_a_o(lane_addr_a_o), .lane_addr_b_o(lane_addr_b_o), .lane_addr_d_o(lane_addr_d_o),
        .lane_scalar_o(lane_scalar_o), .lane_strip_o(lane_strip_o), .lane_wdata_o(lane_wdata_o),
        .lane_done_i(lane_done_i), .lane_v_i(lane_v_i), .lane_data_i(lane_data_i),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
        .done_o(done_o), .busy_o(busy_o)
`ifdef VEC_SEQ_PERF_CNT_EN
        , .perf_busy_cycles_o(perf_busy_cycles_o), .perf_cmds_o(perf_cmds_o)
`endif
    );

    typedef struct packed {
        logic [3:0]           op;
        logic [AW-1:0]        a;
        logic [AW-1:0]        b;
        logic [AW-1:0]        d;
        logic [VDW-1:0]       scalar;
        logic [LANES-1:0]     mask;
        logic [SW-1:0]        strip;
        logic [LANES*VDW-1:0] wdata;
    } issue_t;

    issue_t              exp_issue_q[$];
    logic [AW-1:0]       exp_done_q[$];
    logic [VLEN*VDW-1:0] exp_resp_q[$];
    int checks = 0;
    int errors = 0;

    // Lane model: masked lanes answer after a delay with data = element index
    int  lane_base = 3;
    bit  stagger = 1'b0;
    bit  junk_unmasked = 1'b0;
    int  lane_cnt[LANES];
    logic [SW-1:0] lane_strip_cap[LANES];
    bit  lane_junk[LANES];

    always @(negedge clk_i) begin
        lane_done_i = '0;
        lane_v_i    = '0;
        if (!reset_n_i) begin
            for (int i = 0; i < LANES; i++) lane_cnt[i] = 0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_cnt[i] > 0) begin
                    lane_cnt[i]--;
                    if (lane_cnt[i] == 0) begin
                        lane_done_i[i] = 1'b1;
                        lane_v_i[i]    = 1'b1;
                        lane_data_i[i*VDW +: VDW] = lane_junk[i] ? 8'hEE : 8'(int'(lane_strip_cap[i]) * LANES + i);
                    end
                end
                if (lane_start_o[i]) begin
                    lane_cnt[i]       = lane_base + (stagger ? i : 0);
                    lane_strip_cap[i] = lane_strip_o;
                    lane_junk[i]      = 1'b0;
                end else if (lane_start_o != '0 && junk_unmasked) begin
                    lane_cnt[i]  = 1;
                    lane_junk[i] = 1'b1;
                end
            end
        end
    end

    // Issue scoreboard
    always @(negedge clk_i) begin
        issue_t e;
        if (reset_n_i && lane_start_o != '0) begin
            checks++;
            if (exp_issue_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue: got mask=%b strip=%0d, required no issue", lane_start_o, lane_strip_o);
            end else begin
                e = exp_issue_q.pop_front();
                if (lane_start_o !== e.mask || lane_strip_o !== e.strip || lane_wdata_o !== e.wdata ||
                    lane_op_o !== e.op || lane_addr_a_o !== e.a || lane_addr_b_o !== e.b ||
                    lane_addr_d_o !== e.d || lane_scalar_o !== e.scalar) begin
                    errors++;
                    $display("FAIL issue: got mask=%b strip=%0d wdata=%h op=%h a=%0d b=%0d d=%0d s=%h, required mask=%b strip=%0d wdata=%h op=%h a=%0d b=%0d d=%0d s=%h",
                             lane_start_o, lane_strip_o, lane_wdata_o, lane_op_o, lane_addr_a_o, lane_addr_b_o, lane_addr_d_o, lane_scalar_o,
                             e.mask, e.strip, e.wdata, e.op, e.a, e.b, e.d, e.scalar);
                end else begin
                    $display("issue  op=%h d=%0d strip=%0d mask=%b wdata=%h", e.op, e.d, e.strip, e.mask, e.wdata);
                end
            end
        end
    end

    // Retirement scoreboard: the retiring command's destination is still on lane_addr_d_o
    always @(negedge clk_i) begin
        logic [AW-1:0] ed;
        if (reset_n_i && done_o === 1'b1) begin
            checks++;
            if (exp_done_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got done_o=1 d=%0d, required no done", lane_addr_d_o);
            end else begin
                ed = exp_done_q.pop_front();
                if (lane_addr_d_o !== ed) begin
                    errors++;
                    $display("FAIL done_order: got d=%0d, required d=%0d", lane_addr_d_o, ed);
                end else begin
                    $display("done   d=%0d", ed);
                end
            end
        end
    end

    // Response scoreboard and consumer: data must hold until yumi on the third valid cycle
    int resp_wait = 0;
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            resp_yumi_i = 1'b0;
            resp_wait   = 0;
        end else begin
            resp_yumi_i = 1'b0;
            if (resp_v_o === 1'b1) begin
                checks++;
                if (exp_resp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got data=%h, required no response", resp_data_o);
                end else if (resp_data_o !== exp_resp_q[0]) begin
                    errors++;
                    $display("FAIL resp_data: got %h, required %h", resp_data_o, exp_resp_q[0]);
                end
                resp_wait++;
                if (resp_wait == 3) begin
                    resp_yumi_i = 1'b1;
                    resp_wait   = 0;
                    if (exp_resp_q.size() != 0) void'(exp_resp_q.pop_front());
                    $display("resp   data=%h consumed", resp_data_o);
                end
            end
        end
    end

    function automatic logic [VLEN*VDW-1:0] rand_wdata();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send_cmd(input logic [3:0] op, input logic [AW-1:0] d, input int vl,
                            input logic [VLEN*VDW-1:0] wdata);
        int n;
        int vle;
        issue_t e;
        logic [VLEN*VDW-1:0] r;
        @(negedge clk_i);
        cmd_v_i      = 1'b1;
        cmd_op_i     = op;
        cmd_addr_d_i = d;
        cmd_addr_a_i = d + 3'd1;
        cmd_addr_b_i = d + 3'd2;
        cmd_scalar_i = 8'hA0 | 8'(d);
        cmd_vl_i     = VLW'(vl);
        cmd_wdata_i  = wdata;
        n = 0;
        while (n < 200 && cmd_ready_o !== 1'b1) begin
            @(negedge clk_i);
            n++;
        end
        if (cmd_ready_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: got cmd_ready_o=%b after 200 cycles, required 1", cmd_ready_o);
            cmd_v_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        #1 cmd_v_i = 1'b0;
        vle = (vl > VLEN) ? VLEN : vl;
        for (int s = 0; s * LANES < vle; s++) begin
            e.op = op; e.a = d + 3'd1; e.b = d + 3'd2; e.d = d; e.scalar = 8'hA0 | 8'(d);
            e.strip = SW'(s); e.mask = '0; e.wdata = '0;
            for (int i = 0; i < LANES; i++) begin
                if (s * LANES + i < vle) begin
                    e.mask[i] = 1'b1;
                    e.wdata[i*VDW +: VDW] = wdata[(s*LANES+i)*VDW +: VDW];
                end
            end
            exp_issue_q.push_back(e);
        end
        exp_done_q.push_back(d);
        if (op == OP_READ) begin
            r = '0;
            for (int k = 0; k < vle; k++) r[k*VDW +: VDW] = 8'(k);
            exp_resp_q.push_back(r);
        end
        $display("cmd    op=%h d=%0d vl=%0d accepted", op, d, vl);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (n < 1000 && !(busy_o === 1'b0 && exp_issue_q.size() == 0 &&
                             exp_done_q.size() == 0 && exp_resp_q.size() == 0)) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL %s_drain: got busy=%b pending issue=%0d done=%0d resp=%0d, required all zero",
                     name, busy_o, exp_issue_q.size(), exp_done_q.size(), exp_resp_q.size());
            exp_issue_q.delete(); exp_done_q.delete(); exp_resp_q.delete();
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || resp_v_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b busy=%b done=%b resp_v=%b, required 1 0 0 0", cmd_ready_o, busy_o, done_o, resp_v_o);
        end
        checks++;
        if (lane_start_o !== '0 || resp_data_o !== '0 || lane_strip_o !== '0 || lane_wdata_o !== '0 || lane_op_o !== '0) begin
            errors++;
            $display("FAIL reset_data: got start=%b resp=%h strip=%0d wdata=%h op=%h, required all 0", lane_start_o, resp_data_o, lane_strip_o, lane_wdata_o, lane_op_o);
        end
        reset_n_i = 1'b1;
        $display("reset  released");
    endtask

    task automatic test_add_full();
        lane_base = 3; stagger = 1'b0; junk_unmasked = 1'b0;
        send_cmd(OP_ADD, 3'd1, 16, rand_wdata());
        checks++;
        if (lane_start_o !== 4'b0000) begin
            errors++;
            $display("FAIL latency_early: got lane_start_o=%b one cycle after accept, required 0000", lane_start_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (lane_start_o !== 4'b1111 || lane_strip_o !== 4'd0) begin
            errors++;
            $display("FAIL latency: got lane_start_o=%b strip=%0d two cycles after accept, required 1111 0", lane_start_o, lane_strip_o);
        end
        wait_idle("add_full");
    endtask

    task automatic test_read_partial();
        lane_base = 3; stagger = 1'b0; junk_unmasked = 1'b1;
        send_cmd(OP_READ, 3'd2, 6, rand_wdata());
        wait_idle("read_partial");
        junk_unmasked = 1'b0;
        checks++;
        if (resp_v_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL read_idle: got resp_v=%b busy=%b, required 0 0", resp_v_o, busy_o);
        end
    endtask

    task automatic test_vl_edge();
        lane_base = 2; stagger = 1'b0;
        send_cmd(OP_ADD, 3'd3, 0, rand_wdata());
        @(posedge clk_i);
        #1;
        checks++;
        if (done_o !== 1'b1 || lane_start_o !== 4'b0000) begin
            errors++;
            $display("FAIL vl0_done: got done=%b start=%b, required 1 0000", done_o, lane_start_o);
        end
        wait_idle("vl0");
        send_cmd(OP_MUL, 3'd4, 20, rand_wdata());
        wait_idle("vl20");
        send_cmd(OP_READ, 3'd5, 0, rand_wdata());
        wait_idle("read_vl0");
    endtask

    task automatic test_back_to_back();
        lane_base = 3; stagger = 1'b1;
        send_cmd(OP_WRITE, 3'd4, 5, rand_wdata());
        send_cmd(OP_MUL, 3'd5, 8, rand_wdata());
        send_cmd(OP_READ, 3'd6, 11, rand_wdata());
        checks++;
        if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL fifo_full: got ready=%b busy=%b with two queued, required 0 1", cmd_ready_o, busy_o);
        end
        wait_idle("back_to_back");
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL fifo_drain_ready: got ready=%b, required 1", cmd_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        lane_base = 3; stagger = 1'b0;
        send_cmd(OP_ADD, 3'd7, 16, rand_wdata());
        while (n < 100 && !(lane_start_o != '0 && lane_strip_o == 4'd1)) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL reset_mid_reach: strip 1 never issued, required issue");
        end
        @(posedge clk_i);
        #2 reset_n_i = 1'b0;
        #1;
        exp_issue_q.delete(); exp_done_q.delete(); exp_resp_q.delete();
        checks++;
        if (lane_start_o !== '0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || done_o !== 1'b0 || lane_strip_o !== '0 || lane_op_o !== '0) begin
            errors++;
            $display("FAIL async_reset: got start=%b busy=%b ready=%b done=%b strip=%0d, required 0 0 1 0 0",
                     lane_start_o, busy_o, cmd_ready_o, done_o, lane_strip_o);
        end
        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;
        repeat (6) @(negedge clk_i);
        send_cmd(OP_READ, 3'd1, 4, rand_wdata());
        wait_idle("after_reset");
    endtask

    initial begin
        test_reset();
        test_add_full();
        test_read_partial();
        test_vl_edge();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
